// File: rtl/mul_pkg.sv
// Shared definitions for the iterative shift-add multiplier.
// Holds the FSM state type and default sizing constants.
package mul_pkg;

    localparam int unsigned MUL_WIDTH = 16;
    localparam int unsigned MUL_CNT_W = $clog2(MUL_WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } mul_state_t;

endpackage

// File: rtl/mul_sign_adjust.sv
// Combinational sign handling for signed multiplies: operand magnitudes,
// result negate flag and the two's-complement of the unsigned product.
module mul_sign_adjust #(
    parameter int unsigned WIDTH = 16
) (
    input  logic [WIDTH-1:0]   op_a,
    input  logic [WIDTH-1:0]   op_b,
    input  logic               is_signed,
    input  logic [2*WIDTH-1:0] product,
    output logic [WIDTH-1:0]   mag_a,
    output logic [WIDTH-1:0]   mag_b,
    output logic               negate,
    output logic [2*WIDTH-1:0] product_neg
);

    logic a_neg;
    logic b_neg;

    assign a_neg = is_signed & op_a[WIDTH-1];
    assign b_neg = is_signed & op_b[WIDTH-1];

    // The most negative value negates onto itself, which is its correct unsigned magnitude.
    assign mag_a       = a_neg ? (~op_a + 1'b1) : op_a;
    assign mag_b       = b_neg ? (~op_b + 1'b1) : op_b;
    assign negate      = a_neg ^ b_neg;
    assign product_neg = ~product + 1'b1;

endmodule

// File: rtl/iter_multiplier.sv
// Multi-cycle shift-add multiplier: WIDTH RUN cycles, one-cycle done pulse.
// Optional signed support is enabled by defining ITER_MULTIPLIER_SIGNED_EN.
module iter_multiplier
    import mul_pkg::*;
#(
    parameter int unsigned WIDTH = MUL_WIDTH
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             start,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             is_signed,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] product_lo,
    output logic [WIDTH-1:0] product_hi
);

    localparam int unsigned   CW   = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    mul_state_t state, state_nx;

    logic [CW-1:0]      cnt;
    logic [WIDTH-1:0]   mcand;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] acc_step;
    logic [2*WIDTH-1:0] result;
    logic [WIDTH:0]     upper_sum;
    logic [WIDTH-1:0]   mag_a;
    logic [WIDTH-1:0]   mag_b;
    logic               accept;
    logic               last_step;

    assign accept    = start && ((state == IDLE) || (state == DONE));
    assign last_step = (state == RUN) && (cnt == LAST);
    assign busy      = (state == RUN);
    assign done      = (state == DONE);

    // Multiplier bits live in acc's low half and shift out as product bits shift in.
    assign upper_sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, mcand} : '0);
    assign acc_step  = {upper_sum, acc[WIDTH-1:1]};

`ifdef ITER_MULTIPLIER_SIGNED_EN
    logic               neg_d;
    logic               neg_q;
    logic [2*WIDTH-1:0] prod_neg;

    mul_sign_adjust #(.WIDTH(WIDTH)) u_sign_adjust (
        .op_a        (op_a),
        .op_b        (op_b),
        .is_signed   (is_signed),
        .product     (acc_step),
        .mag_a       (mag_a),
        .mag_b       (mag_b),
        .negate      (neg_d),
        .product_neg (prod_neg)
    );

    assign result = neg_q ? prod_neg : acc_step;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            neg_q <= 1'b0;
        end else if (accept) begin
            neg_q <= neg_d;
        end
    end
`else
    logic sign_unused;

    assign sign_unused = is_signed;
    assign mag_a       = op_a;
    assign mag_b       = op_b;
    assign result      = acc_step;
`endif

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = RUN;
            RUN:     if (cnt == LAST) state_nx = DONE;
            DONE:    state_nx = start ? RUN : IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            cnt        <= '0;
            mcand      <= '0;
            acc        <= '0;
            product_lo <= '0;
            product_hi <= '0;
        end else begin
            if (accept) begin
                cnt   <= '0;
                mcand <= mag_a;
                acc   <= {{WIDTH{1'b0}}, mag_b};
            end else if (state == RUN) begin
                cnt <= cnt + 1'b1;
                acc <= acc_step;
            end
            if (last_step) begin
                product_lo <= result[WIDTH-1:0];
                product_hi <= result[2*WIDTH-1:WIDTH];
            end
        end
    end

endmodule

// File: tb/tb_iter_multiplier.sv
// Self-checking bench for iter_multiplier against an arithmetic reference model.
// Signed expectations follow ITER_MULTIPLIER_SIGNED_EN when it is defined.
module tb_iter_multiplier;

    localparam int unsigned W = 16;

    logic         CLK = 1'b0;
    logic         RST_N = 1'b0;
    logic         start = 1'b0;
    logic         is_signed = 1'b0;
    logic [W-1:0] op_a = '0;
    logic [W-1:0] op_b = '0;
    logic         busy;
    logic         done;
    logic [W-1:0] product_lo;
    logic [W-1:0] product_hi;

    int unsigned total = 0;
    int unsigned bad   = 0;
    logic [2*W-1:0] last_prod = '0;

    always #5 CLK = ~CLK;

    iter_multiplier #(.WIDTH(W)) dut (
        .CLK        (CLK),
        .RST_N      (RST_N),
        .start      (start),
        .op_a       (op_a),
        .op_b       (op_b),
        .is_signed  (is_signed),
        .busy       (busy),
        .done       (done),
        .product_lo (product_lo),
        .product_hi (product_hi)
    );

    function automatic logic [2*W-1:0] ref_mul(input logic [W-1:0] a, input logic [W-1:0] b,
                                               input logic s);
        int sa;
        int sb;
        sa = int'($signed(a));
        sb = int'($signed(b));
`ifdef ITER_MULTIPLIER_SIGNED_EN
        if (s) return 32'(sa * sb);
`else
        if (s && (sa == sb)) return {16'h0, a} * {16'h0, b};
`endif
        return {16'h0, a} * {16'h0, b};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] expv);
        total++;
        if (got !== expv) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, expv);
        end
    endtask

    // Entered on the first falling edge after the accepting rising edge (cyc=1).
    task automatic wait_done(output int cyc, output int nbusy);
        cyc   = 1;
        nbusy = 0;
        while (done !== 1'b1 && cyc < 64) begin
            if (busy === 1'b1) nbusy++;
            check("hold", {product_hi, product_lo}, last_prod);
            @(negedge CLK);
            cyc++;
        end
        check("done_seen", {31'h0, done}, 32'h1);
    endtask

    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
        int cyc;
        int nb;
        logic [2*W-1:0] expv;
        expv      = ref_mul(a, b, s);
        start     = 1'b1;
        op_a      = a;
        op_b      = b;
        is_signed = s;
        @(negedge CLK);
        start     = 1'b0;
        op_a      = W'($urandom);
        op_b      = W'($urandom);
        is_signed = 1'($urandom);
        wait_done(cyc, nb);
        check("latency", cyc, W + 1);
        check("busy_cycles", nb, W);
        check("product", {product_hi, product_lo}, expv);
        last_prod = expv;
        @(negedge CLK);
        check("done_pulse", {31'h0, done}, 32'h0);
        check("idle_busy", {31'h0, busy}, 32'h0);
        check("idle_hold", {product_hi, product_lo}, expv);
    endtask

    initial begin
        int cyc;
        int nb;

        repeat (2) @(negedge CLK);
        check("rst_busy", {31'h0, busy}, 32'h0);
        check("rst_done", {31'h0, done}, 32'h0);
        check("rst_prod", {product_hi, product_lo}, 32'h0);
        RST_N = 1'b1;

        run_op(16'h0003, 16'h0005, 1'b0);
        run_op(16'hFFFF, 16'hFFFF, 1'b0);

        // Start held high: second operation only accepted out of DONE.
        start = 1'b1;
        op_a  = 16'h0002;
        op_b  = 16'h0003;
        is_signed = 1'b0;
        @(negedge CLK);
        op_a = 16'h0004;
        op_b = 16'h0005;
        wait_done(cyc, nb);
        check("b2b_lat1", cyc, W + 1);
        check("b2b_busy1", nb, W);
        check("b2b_prod1", {product_hi, product_lo}, 32'h6);
        last_prod = 32'h6;
        @(negedge CLK);
        start = 1'b0;
        check("b2b_rearm", {31'h0, busy}, 32'h1);
        wait_done(cyc, nb);
        check("b2b_gap", cyc, W + 1);
        check("b2b_prod2", {product_hi, product_lo}, 32'h14);
        last_prod = 32'h14;
        @(negedge CLK);

        // Reset in the middle of RUN aborts without a done pulse.
        start = 1'b1;
        op_a  = 16'h1234;
        op_b  = 16'h5678;
        @(negedge CLK);
        start = 1'b0;
        repeat (7) @(negedge CLK);
        check("pre_abort_busy", {31'h0, busy}, 32'h1);
        RST_N = 1'b0;
        #1;
        check("abort_busy", {31'h0, busy}, 32'h0);
        check("abort_done", {31'h0, done}, 32'h0);
        check("abort_prod", {product_hi, product_lo}, 32'h0);
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            check("abort_nodone", {31'h0, done}, 32'h0);
        end
        RST_N = 1'b1;
        last_prod = '0;
        run_op(16'h1234, 16'h5678, 1'b0);

        run_op(16'hFFFF, 16'h0002, 1'b1);
        run_op(16'h8000, 16'h8000, 1'b1);
        run_op(16'h0000, 16'hFFFF, 1'b0);

        for (int i = 0; i < 24; i++) begin
            run_op(W'($urandom), W'($urandom), 1'($urandom));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
